// File: rtl/bp_pkg.sv
// Shared types and helpers for the BHT branch predictor.
package bp_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        predicted;
    } bp_update_t;

    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7],
                instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic int cnt_init(input int cnt_w, input int init_taken);
        return (init_taken != 0) ? (1 << (cnt_w - 1))
                                 : (1 << (cnt_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Flop array of saturating counters: one comb read, one sync update.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int ENTRIES    = 64,
    parameter int CNT_W      = 2,
    parameter int INIT_TAKEN = 1,
    parameter int IDX_W      = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [CNT_W-1:0] o_rd_cnt,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    localparam logic [CNT_W-1:0] INIT = CNT_W'(cnt_init(CNT_W, INIT_TAKEN));
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] r_cnt [ENTRIES];
    logic [CNT_W-1:0] w_cur;
    logic [CNT_W-1:0] w_next;

    assign o_rd_cnt = r_cnt[i_rd_idx];
    assign w_cur    = r_cnt[i_wr_idx];

    always_comb begin
        w_next = w_cur;
        if (i_wr_taken) begin
            if (w_cur != CMAX) w_next = w_cur + 1'b1;
        end else begin
            if (w_cur != '0) w_next = w_cur - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= INIT;
        end else if (i_wr_en) begin
            r_cnt[i_wr_idx] <= w_next;
        end
    end

endmodule

// File: rtl/bht_branch_predictor.sv
// PC-indexed BHT predictor with B-type target and accuracy statistics.
module bht_branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES    = 64,
    parameter int CNT_W      = 2,
    parameter int INIT_TAKEN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        predict_valid_i,
    input  logic [31:0] predict_pc_i,
    input  logic [31:0] predict_instr_i,
    output logic        predict_taken_o,
    output logic [31:0] predict_target_o,
    input  logic        update_valid_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_taken_i,
    input  logic        update_predicted_i,
    output logic        mispredict_o,
    input  logic        stat_clear_i,
    output logic [31:0] stat_branches_o,
    output logic [31:0] stat_mispredicts_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_update_t       w_upd;
    logic [CNT_W-1:0] w_rd_cnt;
    logic [31:0]      r_stat_branches;
    logic [31:0]      r_stat_mispredicts;
    logic             w_unused;

    assign w_upd = '{pc: update_pc_i,
                     taken: update_taken_i,
                     predicted: update_predicted_i};

    bp_counter_table #(
        .ENTRIES    (ENTRIES),
        .CNT_W      (CNT_W),
        .INIT_TAKEN (INIT_TAKEN),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_idx   (predict_pc_i[IDX_W+1:2]),
        .o_rd_cnt   (w_rd_cnt),
        .i_wr_en    (update_valid_i),
        .i_wr_idx   (w_upd.pc[IDX_W+1:2]),
        .i_wr_taken (w_upd.taken)
    );

    assign predict_taken_o  = predict_valid_i & w_rd_cnt[CNT_W-1];
    assign predict_target_o = predict_pc_i + b_imm(predict_instr_i);
    assign mispredict_o     = update_valid_i & (w_upd.taken != w_upd.predicted);

    // Clear beats a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (stat_clear_i) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (update_valid_i) begin
            if (r_stat_branches != '1)
                r_stat_branches <= r_stat_branches + 1'b1;
            if (mispredict_o && (r_stat_mispredicts != '1))
                r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
        end
    end

    assign stat_branches_o    = r_stat_branches;
    assign stat_mispredicts_o = r_stat_mispredicts;

    assign w_unused = ^{w_upd.pc[31:IDX_W+2], w_upd.pc[1:0],
                        predict_instr_i[24:12], predict_instr_i[6:0]};

endmodule

// File: tb/tb_bht_branch_predictor.sv
// Directed self-checking bench for bht_branch_predictor.
module tb_bht_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        predict_valid_i;
    logic [31:0] predict_pc_i;
    logic [31:0] predict_instr_i;
    logic        update_valid_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;
    logic        update_predicted_i;
    logic        stat_clear_i;

    logic        taken_o;
    logic [31:0] target_o;
    logic        misp_o;
    logic [31:0] br_o;
    logic [31:0] mp_o;

    logic        t1_taken_o;
    logic [31:0] t1_target_o;
    logic        t1_misp_o;
    logic [31:0] t1_br_o;
    logic [31:0] t1_mp_o;

    int n_checks = 0;
    int n_fail   = 0;

    bht_branch_predictor dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .predict_valid_i    (predict_valid_i),
        .predict_pc_i       (predict_pc_i),
        .predict_instr_i    (predict_instr_i),
        .predict_taken_o    (taken_o),
        .predict_target_o   (target_o),
        .update_valid_i     (update_valid_i),
        .update_pc_i        (update_pc_i),
        .update_taken_i     (update_taken_i),
        .update_predicted_i (update_predicted_i),
        .mispredict_o       (misp_o),
        .stat_clear_i       (stat_clear_i),
        .stat_branches_o    (br_o),
        .stat_mispredicts_o (mp_o)
    );

    bht_branch_predictor #(.CNT_W(1)) dut1 (
        .clk                (clk),
        .rst_n              (rst_n),
        .predict_valid_i    (predict_valid_i),
        .predict_pc_i       (predict_pc_i),
        .predict_instr_i    (predict_instr_i),
        .predict_taken_o    (t1_taken_o),
        .predict_target_o   (t1_target_o),
        .update_valid_i     (update_valid_i),
        .update_pc_i        (update_pc_i),
        .update_taken_i     (update_taken_i),
        .update_predicted_i (update_predicted_i),
        .mispredict_o       (t1_misp_o),
        .stat_clear_i       (stat_clear_i),
        .stat_branches_o    (t1_br_o),
        .stat_mispredicts_o (t1_mp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n              = 1'b0;
        predict_valid_i    = 1'b0;
        predict_pc_i       = '0;
        predict_instr_i    = '0;
        update_valid_i     = 1'b0;
        update_pc_i        = '0;
        update_taken_i     = 1'b0;
        update_predicted_i = 1'b0;
        stat_clear_i       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic pr);
        update_valid_i     = 1'b1;
        update_pc_i        = pc;
        update_taken_i     = tk;
        update_predicted_i = pr;
        @(negedge clk);
        update_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        predict_valid_i = 1'b1;
        predict_pc_i    = 32'h100;
        predict_instr_i = 32'hFE00_0EE3;
        #1;
        n_checks++;
        if (taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pred: got %b want 1", taken_o);
        end
        n_checks++;
        if (target_o !== 32'h0FC) begin
            n_fail++;
            $display("FAIL reset_target: got %h want 000000fc", target_o);
        end
        n_checks++;
        if (br_o !== 32'd0 || mp_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got %0d/%0d want 0/0", br_o, mp_o);
        end
        n_checks++;
        if (t1_taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pred_c1: got %b want 1", t1_taken_o);
        end
        predict_valid_i = 1'b0;
        #1;
        n_checks++;
        if (taken_o !== 1'b0 || misp_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_out: got %b/%b want 0/0", taken_o, misp_o);
        end
        @(negedge clk);
    endtask

    task automatic test_training();
        do_reset();
        predict_valid_i = 1'b1;
        predict_pc_i    = 32'h100;
        upd(32'h100, 1'b0, 1'b1);
        upd(32'h100, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL train_nt2: got %b want 0", taken_o);
        end
        upd(32'h100, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL train_t1: got %b want 0", taken_o);
        end
        upd(32'h100, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL train_t2: got %b want 1", taken_o);
        end
        for (int i = 0; i < 5; i++) upd(32'h100, 1'b1, 1'b1);
        upd(32'h100, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL train_sat: got %b want 1", taken_o);
        end
        predict_pc_i = 32'h104;
        #1;
        n_checks++;
        if (taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL train_neighbor: got %b want 1", taken_o);
        end
        @(negedge clk);
    endtask

    task automatic test_cnt1_alias();
        do_reset();
        predict_valid_i = 1'b1;
        upd(32'h100, 1'b0, 1'b1);
        predict_pc_i = 32'h100;
        #1;
        n_checks++;
        if (t1_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL c1_flip_nt: got %b want 0", t1_taken_o);
        end
        predict_pc_i = 32'h200;
        #1;
        n_checks++;
        if (t1_taken_o !== 1'b0 || taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_200: got %b/%b want 0/0", t1_taken_o, taken_o);
        end
        @(negedge clk);
        upd(32'h200, 1'b1, 1'b0);
        predict_pc_i = 32'h100;
        #1;
        n_checks++;
        if (t1_taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL c1_flip_t: got %b want 1", t1_taken_o);
        end
        @(negedge clk);
    endtask

    task automatic test_same_cycle();
        do_reset();
        predict_valid_i    = 1'b1;
        predict_pc_i       = 32'h40;
        update_valid_i     = 1'b1;
        update_pc_i        = 32'h40;
        update_taken_i     = 1'b0;
        update_predicted_i = 1'b1;
        #1;
        n_checks++;
        if (taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL same_pre: got %b want 1", taken_o);
        end
        @(negedge clk);
        update_valid_i = 1'b0;
        #1;
        n_checks++;
        if (taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL same_post: got %b want 0", taken_o);
        end
        @(negedge clk);
    endtask

    task automatic test_stats();
        do_reset();
        upd(32'h100, 1'b1, 1'b1);
        update_valid_i     = 1'b1;
        update_pc_i        = 32'h100;
        update_taken_i     = 1'b0;
        update_predicted_i = 1'b1;
        #1;
        n_checks++;
        if (misp_o !== 1'b1) begin
            n_fail++;
            $display("FAIL misp_comb: got %b want 1", misp_o);
        end
        n_checks++;
        if (br_o !== 32'd1) begin
            n_fail++;
            $display("FAIL stat_lag: got %0d want 1", br_o);
        end
        @(negedge clk);
        update_valid_i = 1'b0;
        upd(32'h100, 1'b1, 1'b1);
        n_checks++;
        if (br_o !== 32'd3 || mp_o !== 32'd1) begin
            n_fail++;
            $display("FAIL stat_3_1: got %0d/%0d want 3/1", br_o, mp_o);
        end
        stat_clear_i = 1'b1;
        upd(32'h100, 1'b0, 1'b1);
        stat_clear_i = 1'b0;
        n_checks++;
        if (br_o !== 32'd0 || mp_o !== 32'd0) begin
            n_fail++;
            $display("FAIL stat_clear: got %0d/%0d want 0/0", br_o, mp_o);
        end
        force dut.r_stat_branches = 32'hFFFF_FFFE;
        #1;
        release dut.r_stat_branches;
        upd(32'h100, 1'b1, 1'b1);
        n_checks++;
        if (br_o !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL stat_reach_max: got %h want ffffffff", br_o);
        end
        upd(32'h100, 1'b1, 1'b1);
        n_checks++;
        if (br_o !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL stat_sat: got %h want ffffffff", br_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        upd(32'h100, 1'b0, 1'b1);
        upd(32'h100, 1'b0, 1'b0);
        upd(32'h40, 1'b0, 1'b1);
        upd(32'h40, 1'b0, 1'b0);
        predict_valid_i = 1'b1;
        predict_pc_i    = 32'h100;
        #1;
        n_checks++;
        if (taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_trained: got %b want 0", taken_o);
        end
        #1;
        rst_n              = 1'b0;
        update_valid_i     = 1'b1;
        update_pc_i        = 32'h100;
        update_taken_i     = 1'b0;
        update_predicted_i = 1'b0;
        #1;
        n_checks++;
        if (taken_o !== 1'b1 || br_o !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_async: got %b/%0d want 1/0", taken_o, br_o);
        end
        @(negedge clk);
        update_valid_i = 1'b0;
        rst_n          = 1'b1;
        predict_pc_i   = 32'h40;
        #1;
        n_checks++;
        if (taken_o !== 1'b1 || t1_taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_bias: got %b/%b want 1/1", taken_o, t1_taken_o);
        end
        predict_pc_i = 32'h100;
        #1;
        n_checks++;
        if (taken_o !== 1'b1 || br_o !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_discard: got %b/%0d want 1/0", taken_o, br_o);
        end
        @(negedge clk);
    endtask

    task automatic test_target();
        predict_pc_i    = 32'hFFFF_FFFC;
        predict_instr_i = 32'h0000_0400;
        #1;
        n_checks++;
        if (target_o !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL tgt_wrap: got %h want 00000004", target_o);
        end
        predict_pc_i    = 32'h0000_1000;
        predict_instr_i = 32'h7E00_0F80;
        #1;
        n_checks++;
        if (target_o !== 32'h0000_1FFE) begin
            n_fail++;
            $display("FAIL tgt_maxpos: got %h want 00001ffe", target_o);
        end
        predict_instr_i = 32'h8000_0000;
        #1;
        n_checks++;
        if (target_o !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL tgt_maxneg: got %h want 00000000", target_o);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_training();
        test_cnt1_alias();
        test_same_cycle();
        test_stats();
        test_reset_mid();
        test_target();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bht_branch_predictor.md
# bht_branch_predictor

Parametrised branch-history-table predictor for the CV32E40P fetch path: one saturating counter per table entry, indexed by PC, replacing the single global taken/not-taken bit. The IF stage gets a combinational taken prediction and B-type target. EX resolves the branch and writes back the outcome. Free-running branch and mispredict counters expose predictor accuracy to the verification environment.

## Interface
- ENTRIES, 64, number of table entries; power of two, 2..1024
- CNT_W, 2, counter width in bits, 1..3 (1 = last-outcome predictor)
- INIT_TAKEN, 1, reset bias: 1 = weakly taken, 0 = weakly not-taken

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- predict_valid_i  in  1  IF holds a conditional branch this cycle
- predict_pc_i  in  32  PC of that branch
- predict_instr_i  in  32  fetched instruction word (B-type)
- predict_taken_o  out  1  prediction; 0 when predict_valid_i=0
- predict_target_o  out  32  predict_pc_i + B-immediate; always driven
- update_valid_i  in  1  EX resolved a conditional branch this cycle
- update_pc_i  in  32  PC of the resolved branch
- update_taken_i  in  1  actual outcome
- update_predicted_i  in  1  prediction that was issued for it
- mispredict_o  out  1  update_valid_i & (update_taken_i != update_predicted_i), combinational
- stat_clear_i  in  1  synchronous clear of both statistics counters
- stat_branches_o  out  32  resolved-branch count
- stat_mispredicts_o  out  32  mispredict count

## Operation
- IDX_W = log2(ENTRIES). Index = pc[IDX_W+1:2]; no tag, so aliasing is permitted.
- Counter reset value: INIT_TAKEN ? 2^(CNT_W-1) : 2^(CNT_W-1)-1. CNT_W=2 gives 2'b10 / 2'b01; CNT_W=1 gives 1 / 0.
- Prediction: predict_taken_o = predict_valid_i & msb(counter[predict index]).
- Target computation:
  - imm = sign-extend{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} to 32 bits.
  - Target = pc + imm mod 2^32; wrap-around is silent.
  - The instruction opcode is not checked.
- Update, when update_valid_i=1: counter[update index] is incremented if taken, decremented if not taken, saturating at 2^CNT_W-1 and 0. Saturation holds the value.
- update_predicted_i affects statistics and mispredict_o only, never the counter.
- Statistics, on each update_valid_i:
  - stat_branches_o increments by 1.
  - stat_mispredicts_o increments by 1 if mispredict_o.
  - Both saturate at 32'hFFFF_FFFF.
  - stat_clear_i=1 zeroes both and wins over a same-cycle increment; that increment is lost.
- Reset: every counter returns to its reset value and both statistics read 0, asynchronously. An update in the reset cycle is discarded.

## Timing
- predict_taken_o, predict_target_o and mispredict_o are combinational, with zero latency.
- A counter write lands on the clock edge. It is visible to predictions from the next cycle onward.
- Same index predicted and updated in the same cycle: prediction uses the pre-update value (no bypass).
- Statistics outputs are registered; they reflect an update one cycle after update_valid_i.
- No handshake or backpressure; every valid pulse is consumed in its cycle.

## Structure
- Package bp_pkg holds:
  - function b_imm(instr) → 32-bit sign-extended offset
  - function cnt_init(CNT_W, INIT_TAKEN)
  - typedef bp_update_t {pc, taken, predicted}
- Sub-module bp_counter_table (params ENTRIES, CNT_W, INIT_TAKEN):
  - one combinational read port and one synchronous saturating-update port
  - flop array with asynchronous reset (no SRAM, since reset init is required)
- The top level contains target add, mispredict compare and statistics counters.

## Test plan
- Reset with defaults; predict pc=0x100 → predict_taken_o=1. Instr 0xFE000EE3 (imm −4) → target 0x0FC. Stats read 0.
- Two not-taken updates at pc=0x100 → next predict 0. One taken update → still 0. Second taken update → 1. Verify saturation after 5 taken updates: one not-taken still predicts 1.
- CNT_W=1: a single not-taken update flips pc=0x100 to 0, and one taken update flips it back. pc=0x200 with ENTRIES=64 aliases to 0x100 (same index).
- Same cycle: predict and update(not-taken) at pc=0x40 from weakly-taken → prediction 1; next cycle prediction 0.
- Apply 3 updates with 1 mispredict → stats 3/1 one cycle later. stat_clear_i with a simultaneous update → 0/0. Force 2^32 branches via backdoor preset → holds 0xFFFF_FFFF.
- Assert rst_n mid-sequence after training counters → all predictions return to the INIT_TAKEN bias immediately. predict_pc=0xFFFF_FFFC with imm +8 → target wraps to 0x0000_0004.
